// File: rtl/ulight_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ulight_pkg
// Purpose  : Shared constants for the uLight SpaceWire receive buffer.
//            Character format and status_out field positions.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// status_out layout, with AW = pointer width:
//   [AW-1:0]        count (low AW bits; a full FIFO reads 0 here, full = 1
//                   distinguishes DEPTH entries from none)
//   [AW+0]          empty
//   [AW+1]          full
//   [AW+2]          underflow (sticky)
//   [AW+3]          overflow  (sticky)
//   [2*AW+4:AW+4]   eop_count (only with ULIGHT_RX_EOP_COUNT_EN)
// ============================================================================
package ulight_pkg;

    localparam int ULIGHT_CHAR_W   = 9;
    localparam int ULIGHT_FLAG_BIT = 8;

    // Field offsets; the flag and eop fields are relative to AW.
    localparam int ST_COUNT_LSB  = 0;
    localparam int ST_EMPTY_REL  = 0;
    localparam int ST_FULL_REL   = 1;
    localparam int ST_UNDER_REL  = 2;
    localparam int ST_OVER_REL   = 3;
    localparam int ST_EOP_REL    = 4;

    // Total status width for a given pointer width.
    function automatic int status_width(input int aw, input bit eop_en);
        return eop_en ? (2 * aw + 5) : (aw + 4);
    endfunction

endpackage : ulight_pkg
`default_nettype wire

// File: rtl/ulight_fifo_mem.sv
`default_nettype none
// ============================================================================
// Module   : ulight_fifo_mem
// Purpose  : DEPTH x 9 character storage. One synchronous write port, one
//            asynchronous read port. The array has no reset; validity of
//            entries is tracked by the pointers in the parent.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports:
//   clk      in   clock
//   wr_en    in   write strobe
//   wr_addr  in   AW   write address
//   wr_data  in   9    write character
//   rd_addr  in   AW   read address
//   rd_data  out  9    character at rd_addr (combinational)
// ============================================================================
module ulight_fifo_mem
    import ulight_pkg::*;
#(
    parameter int DEPTH = 64,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic                     clk,
    input  logic                     wr_en,
    input  logic [AW-1:0]            wr_addr,
    input  logic [ULIGHT_CHAR_W-1:0] wr_data,
    input  logic [AW-1:0]            rd_addr,
    output logic [ULIGHT_CHAR_W-1:0] rd_data
);

    logic [ULIGHT_CHAR_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule : ulight_fifo_mem
`default_nettype wire

// File: rtl/ulight_fifo_rx_buffer.sv
`default_nettype none
// ============================================================================
// Module   : ulight_fifo_rx_buffer
// Purpose  : Receive-side character FIFO for the uLight SpaceWire link.
//            Accepts 9-bit characters over valid/ready, presents the head
//            character and status to software PIO ports, and pops one
//            character per level change of rd_toggle.
// Revision : 1.0 - initial release
// Config   : define ULIGHT_RX_EOP_COUNT_EN to add a packet-end counter in
//            the MSBs of status_out (width 2*AW+5 instead of AW+4).
// ----------------------------------------------------------------------------
// Ports:
//   clk            in   clock
//   reset          in   synchronous active-high reset
//   rx_data        in   9      character, bit 8 = EOP/EEP flag
//   rx_valid       in   1      rx_data valid
//   rx_ready       out  1      buffer can accept (not full)
//   rd_toggle      in   1      each level change requests one pop
//   sw_clear       in   1      single-cycle flush
//   data_flag_out  out  9      registered head character (0 when empty)
//   status_out     out  AW+4   {overflow, underflow, full, empty, count}
//                              (eop_count prepended when enabled)
// ============================================================================
module ulight_fifo_rx_buffer
    import ulight_pkg::*;
#(
    parameter int DEPTH = 64,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [ULIGHT_CHAR_W-1:0] rx_data,
    input  logic                     rx_valid,
    output logic                     rx_ready,
    input  logic                     rd_toggle,
    input  logic                     sw_clear,
    output logic [ULIGHT_CHAR_W-1:0] data_flag_out,
`ifdef ULIGHT_RX_EOP_COUNT_EN
    output logic [2*AW+4:0]          status_out
`else
    output logic [AW+3:0]            status_out
`endif
);

    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

    logic [AW-1:0]            wr_ptr;
    logic [AW-1:0]            rd_ptr;
    logic [AW-1:0]            wr_ptr_next;
    logic [AW-1:0]            rd_ptr_next;
    logic [AW:0]              count;
    logic [AW:0]              count_next;
    logic                     empty;
    logic                     full;
    logic                     overflow;
    logic                     underflow;
    logic                     rd_toggle_q;
    logic                     pop_req;
    logic                     push;
    logic                     pop;
    logic                     flush;
    logic [ULIGHT_CHAR_W-1:0] mem_rd_data;
    logic [ULIGHT_CHAR_W-1:0] head_next;

    assign flush    = reset || sw_clear;
    assign rx_ready = !full;
    assign pop_req  = rd_toggle ^ rd_toggle_q;
    assign push     = rx_valid && !full;
    assign pop      = pop_req && !empty;

    // Storage is read at the next read pointer so the head register can be
    // loaded with the character that will be at the head after this edge.
    ulight_fifo_mem #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk     (clk),
        .wr_en   (push && !flush),
        .wr_addr (wr_ptr),
        .wr_data (rx_data),
        .rd_addr (rd_ptr_next),
        .rd_data (mem_rd_data)
    );

    always_comb begin
        wr_ptr_next = wr_ptr;
        rd_ptr_next = rd_ptr;
        count_next  = count;
        if (push) begin
            wr_ptr_next = wr_ptr + 1'b1;
        end
        if (pop) begin
            rd_ptr_next = rd_ptr + 1'b1;
        end
        case ({push, pop})
            2'b10:   count_next = count + 1'b1;
            2'b01:   count_next = count - 1'b1;
            default: count_next = count;
        endcase

        // When the next head slot is the one being written this edge the
        // array still holds stale data, so forward the incoming character.
        if (push && (rd_ptr_next == wr_ptr)) begin
            head_next = rx_data;
        end else begin
            head_next = mem_rd_data;
        end
        if (count_next == '0) begin
            head_next = '0;
        end
    end

    always_ff @(posedge clk) begin
        // Track the toggle level unconditionally so neither reset nor a
        // flush leaves a pending edge behind.
        rd_toggle_q <= rd_toggle;
        if (flush) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            count         <= '0;
            empty         <= 1'b1;
            full          <= 1'b0;
            overflow      <= 1'b0;
            underflow     <= 1'b0;
            data_flag_out <= '0;
        end else begin
            wr_ptr        <= wr_ptr_next;
            rd_ptr        <= rd_ptr_next;
            count         <= count_next;
            empty         <= (count_next == '0);
            full          <= (count_next == DEPTH_C);
            data_flag_out <= head_next;
            if (rx_valid && full) begin
                overflow <= 1'b1;
            end
            if (pop_req && empty) begin
                underflow <= 1'b1;
            end
        end
    end

`ifdef ULIGHT_RX_EOP_COUNT_EN
    logic [AW:0] eop_count;
    logic        push_eop;
    logic        pop_eop;

    // The character leaving on a pop is the current head register.
    assign push_eop = push && rx_data[ULIGHT_FLAG_BIT];
    assign pop_eop  = pop && data_flag_out[ULIGHT_FLAG_BIT];

    always_ff @(posedge clk) begin
        if (flush) begin
            eop_count <= '0;
        end else begin
            case ({push_eop, pop_eop})
                2'b10:   eop_count <= eop_count + 1'b1;
                2'b01:   eop_count <= eop_count - 1'b1;
                default: eop_count <= eop_count;
            endcase
        end
    end
`endif

    always_comb begin
        status_out                              = '0;
        status_out[ST_COUNT_LSB +: AW]          = count[AW-1:0];
        status_out[AW + ST_EMPTY_REL]           = empty;
        status_out[AW + ST_FULL_REL]            = full;
        status_out[AW + ST_UNDER_REL]           = underflow;
        status_out[AW + ST_OVER_REL]            = overflow;
`ifdef ULIGHT_RX_EOP_COUNT_EN
        status_out[AW + ST_EOP_REL +: AW + 1]   = eop_count;
`endif
    end

endmodule : ulight_fifo_rx_buffer
`default_nettype wire
